carry_skip_adder_pipe: RTL and testbench
========================================

Name: carry_skip_adder_pipe

Overview:
Parametrised, pipelined carry-skip adder, WIDTH bits wide, built from BLK-bit ripple blocks that have a group-propagate skip mux. The operand is split into SEG-bit pipeline segments, and each stage resolves one segment per cycle. A valid/ready handshake with full backpressure on both sides lets the block sit directly in a streaming datapath. It is the successor to the fixed 16-bit, purely combinational carry-skip adder.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of SEG
SEG, 8, bits resolved per pipeline stage; must be a multiple of BLK
BLK, 4, carry-skip block size in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands presented
in_ready  out  1  stage 0 can accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in
out_valid  out  1  result available
out_ready  in  1  consumer accepts
sum  out  WIDTH  result
cout  out  1  carry out of MSB
ovf  out  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- NSTG = WIDTH/SEG stages; latency is exactly NSTG cycles from input accept to out_valid when there is no stall. Defaults give 4 stages.
- Any non-integer WIDTH/SEG or SEG/BLK is an elaboration-time error.
- Stage k adds bits [k*SEG +: SEG], using the carry registered by stage k-1. Stage 0 uses cin.
- Operand bits above the current segment travel forward unchanged (skewed). Completed sum bits travel forward to realign (deskewed).
- Within a segment: block carry-out = P_blk ? block_cin : ripple_cout, where P_blk is the AND of (a^b) over the block.
- Each stage holds a valid bit.
  - ready_k = !valid_k || ready_{k+1}; ready_NSTG = out_ready.
  - in_ready = ready_0.
  - A stage loads when ready_k is high; valid_k takes the previous stage's valid.
- Bubbles collapse: an empty stage accepts new data even while the output is stalled.
- While out_valid=1 and out_ready=0, sum/cout/ovf hold stable.
- Transfer happens only on valid&&ready; there are no combinational paths from in_valid to out_valid.
- in_ready depends combinationally on out_ready through the ready chain. This chain is accepted for NSTG≤8.
- On reset:
  - all valid bits clear, so out_valid=0;
  - sum=0, cout=0, ovf=0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight results. No partial result emerges after reset deasserts.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput of one result per cycle.
- Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit.

Optional Feature:
Macro CSA_SUB_EN.
- Defined:
  - adds input port `sub` (1 bit), sampled with a;
  - when sub=1, operand B is inverted and the effective carry-in is forced to 1, so cin is ignored and the result is a-b;
  - cout=1 means no borrow; ovf reports signed subtract overflow.
- Undefined: no `sub` port; addition only.

Decomposition:
- Package csa_pkg holds:
  - function nstg(WIDTH,SEG);
  - localparam checks;
  - a stage record typedef (valid, carry, partial sum, pending a/b, sub flag).
- Sub-module csa_segment: combinational SEG-bit carry-skip chain of SEG/BLK blocks with inputs a, b, ci and outputs s, co, c_msb_in. The top instantiates NSTG copies plus the pipeline registers.

Test Plan:
1. Defaults, a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> after 4 cycles sum=0x0000_0000, cout=1, ovf=0. This is a full skip-chain propagate.
2. a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
3. Back-to-back stream of 100 random pairs with out_ready=1 -> one result per cycle after 4-cycle fill; every result matches a+b+cin.
4. out_ready held 0 for 10 cycles while feeding -> in_ready drops after exactly 4 accepts; sum stays stable; no loss or duplication after release.
5. rst asserted with 3 operations in flight -> next cycle out_valid=0, sum=0, in_ready=1; the first post-reset result is the first post-reset input.
6. With CSA_SUB_EN, a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0. Also sweep WIDTH=16/SEG=4/BLK=4 with a=0x1234, b=0xEDCC -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared helpers and the per-stage control record for the pipelined carry-skip adder.
package csa_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;
    localparam int DEF_BLK   = 4;

    function automatic int nstg(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic int nblk(input int seg, input int blk);
        return seg / blk;
    endfunction

    // Widths must tile exactly: WIDTH into segments, each segment into skip blocks.
    function automatic bit params_ok(input int width, input int seg, input int blk);
        return (width > 0) && (seg > 0) && (blk > 0) &&
               (width % seg == 0) && (seg % blk == 0);
    endfunction

    // Control half of a stage record; the operand and partial-sum words sit in
    // WIDTH-sized arrays beside it because they depend on the instance width.
    typedef struct packed {
        logic valid;
        logic carry;
        logic cMsb;
        logic sub;
    } stage_ctl_t;

endpackage

// File: rtl/csa_segment.sv
// Combinational SEG-bit carry-skip chain: SEG/BLK ripple blocks, each with a group-propagate bypass.
module csa_segment
    import csa_pkg::*;
#(
    parameter int SEG = DEF_SEG,
    parameter int BLK = DEF_BLK
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    localparam int NBLK = nblk(SEG, BLK);

    if ((BLK <= 0) || (SEG % BLK != 0)) begin : g_bad_params
        $error("csa_segment: SEG must be a positive multiple of BLK");
    end

    logic carry;
    logic blkCin;
    logic blkP;

    // When every bit of a block propagates, its carry-out is the block carry-in,
    // so the long carry path can bypass the block's ripple.
    always_comb begin
        carry    = ci;
        s        = '0;
        c_msb_in = 1'b0;
        blkCin   = 1'b0;
        blkP     = 1'b0;
        for (int j = 0; j < NBLK; j++) begin
            blkCin = carry;
            blkP   = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                blkP           = blkP & (a[j*BLK+i] ^ b[j*BLK+i]);
                s[j*BLK+i]     = a[j*BLK+i] ^ b[j*BLK+i] ^ carry;
                if (j*BLK+i == SEG-1) begin
                    c_msb_in = carry;
                end
                carry = (a[j*BLK+i] & b[j*BLK+i]) | (carry & (a[j*BLK+i] ^ b[j*BLK+i]));
            end
            carry = blkP ? blkCin : carry;
        end
        co = carry;
    end

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder, one SEG-bit segment per stage, valid/ready on both sides.
// Optional subtract mode is compiled in with the CSA_SUB_EN macro.
module carry_skip_adder_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = nstg(WIDTH, SEG);

    if (!params_ok(WIDTH, SEG, BLK)) begin : g_bad_params
        $error("carry_skip_adder_pipe: WIDTH must be a multiple of SEG and SEG a multiple of BLK");
    end

    stage_ctl_t       ctl_q   [NSTG];
    stage_ctl_t       ctl_d   [NSTG];
    stage_ctl_t       ctlIn   [NSTG];
    logic [WIDTH-1:0] a_q     [NSTG];
    logic [WIDTH-1:0] b_q     [NSTG];
    logic [WIDTH-1:0] sum_q   [NSTG];
    logic [WIDTH-1:0] sum_d   [NSTG];
    logic [WIDTH-1:0] aIn     [NSTG];
    logic [WIDTH-1:0] bIn     [NSTG];
    logic [WIDTH-1:0] sumIn   [NSTG];
    logic [SEG-1:0]   segB    [NSTG];
    logic [SEG-1:0]   segS    [NSTG];
    logic [NSTG-1:0]  segCo;
    logic [NSTG-1:0]  segCmsb;
    logic [NSTG:0]    ready;
    logic             rdy;
    logic             subIn;

`ifdef CSA_SUB_EN
    assign subIn = sub;
`else
    assign subIn = 1'b0;
`endif

    // Stage 0 takes the ports; later stages take the record registered one stage back.
    // Subtraction inverts B per segment, so the pending operand stays as presented.
    always_comb begin
        ctlIn[0].valid = in_valid;
        ctlIn[0].carry = subIn ? 1'b1 : cin;
        ctlIn[0].cMsb  = 1'b0;
        ctlIn[0].sub   = subIn;
        aIn[0]         = a;
        bIn[0]         = b;
        sumIn[0]       = '0;
        for (int k = 1; k < NSTG; k++) begin
            ctlIn[k] = ctl_q[k-1];
            aIn[k]   = a_q[k-1];
            bIn[k]   = b_q[k-1];
            sumIn[k] = sum_q[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            segB[k] = ctlIn[k].sub ? ~bIn[k][k*SEG +: SEG] : bIn[k][k*SEG +: SEG];
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_seg
        csa_segment #(
            .SEG (SEG),
            .BLK (BLK)
        ) u_seg (
            .a        (aIn[g][g*SEG +: SEG]),
            .b        (segB[g]),
            .ci       (ctlIn[g].carry),
            .s        (segS[g]),
            .co       (segCo[g]),
            .c_msb_in (segCmsb[g])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            sum_d[k]                 = sumIn[k];
            sum_d[k][k*SEG +: SEG]   = segS[k];
            ctl_d[k]                 = ctlIn[k];
            ctl_d[k].carry           = segCo[k];
            ctl_d[k].cMsb            = segCmsb[k];
        end
    end

    // An empty stage is always ready, which lets bubbles collapse under a stalled output.
    always_comb begin
        ready       = '0;
        rdy         = out_ready;
        ready[NSTG] = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy      = !ctl_q[k].valid || rdy;
            ready[k] = rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (ready[k]) begin
                    if (ctlIn[k].valid) begin
                        ctl_q[k] <= ctl_d[k];
                        a_q[k]   <= aIn[k];
                        b_q[k]   <= bIn[k];
                        sum_q[k] <= sum_d[k];
                    end else begin
                        ctl_q[k].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = ctl_q[NSTG-1].valid;
    assign sum       = sum_q[NSTG-1];
    assign cout      = ctl_q[NSTG-1].carry;
    assign ovf       = ctl_q[NSTG-1].carry ^ ctl_q[NSTG-1].cMsb;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Self-checking bench for carry_skip_adder_pipe: arithmetic reference model plus directed corner cases.
// Subtract cases are included when CSA_SUB_EN is defined.
module tb_carry_skip_adder_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        cin;
    logic        sub;
    logic        outValid;
    logic        outReady;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        inValid16;
    logic        inReady16;
    logic [15:0] opA16;
    logic [15:0] opB16;
    logic        outValid16;
    logic [15:0] sum16;
    logic        cout16;
    logic        ovf16;
    logic        sub16;

    int   errors    = 0;
    int   checks    = 0;
    int   popCount  = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    carry_skip_adder_pipe #(
        .WIDTH (32),
        .SEG   (8),
        .BLK   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .cin       (cin),
`ifdef CSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    carry_skip_adder_pipe #(
        .WIDTH (16),
        .SEG   (4),
        .BLK   (4)
    ) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid16),
        .in_ready  (inReady16),
        .a         (opA16),
        .b         (opB16),
        .cin       (1'b0),
`ifdef CSA_SUB_EN
        .sub       (sub16),
`endif
        .out_valid (outValid16),
        .out_ready (1'b1),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic exp_t refModel(input logic [31:0] x, input logic [31:0] y,
                                      input logic c, input logic s);
        exp_t            r;
        longint unsigned u;
        longint          sx;
        longint          sy;
        longint          sres;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sres   = sx - sy;
        end else begin
            u      = 64'(x) + 64'(y) + 64'(c);
            r.sum  = u[31:0];
            r.cout = u[32];
            sres   = sx + sy + (c ? 64'sd1 : 64'sd0);
        end
        r.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return r;
    endfunction

    // Scoreboard: everything on the wires is stable at the falling edge and is what the
    // next rising edge will transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expQ.delete();
        end else begin
            if (outValid && outReady) begin
                popCount++;
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_sum", 64'(sum), 64'(e.sum));
                    checkOutput("sb_cout", 64'(cout), 64'(e.cout));
                    checkOutput("sb_ovf", 64'(ovf), 64'(e.ovf));
                end
            end
            if (inValid && inReady) begin
                expQ.push_back(refModel(opA, opB, cin, sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
        opA = x;
        opB = y;
        cin = c;
        sub = s;
    endtask

    function automatic logic randSub();
`ifdef CSA_SUB_EN
        return logic'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic runDirected(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic c, input logic s, input logic [31:0] expSum,
                               input logic expCout, input logic expOvf);
        int cyc;
        applyStimulus(x, y, c, s);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        cyc = 1;
        while (!outValid && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc), 64'd4);
        checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(expCout));
        checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
        tick();
    endtask

    initial begin
        int          acc;
        int          stalls;
        int          extra;
        int          base;
        int          unstable;
        int          cyc;
        logic        took;
        logic        seen;
        logic [31:0] held;

        rst       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b1;
        inValid16 = 1'b0;
        opA16     = '0;
        opB16     = '0;
        sub16     = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_out_valid", 64'(outValid), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        checkOutput("reset_in_ready", 64'(inReady), 64'd1);

        runDirected("full_propagate", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                    32'h0000_0000, 1'b1, 1'b0);
        runDirected("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                    32'h8000_0000, 1'b0, 1'b1);
        runDirected("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
                    32'h0000_0001, 1'b1, 1'b1);
`ifdef CSA_SUB_EN
        runDirected("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runDirected("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        // Back-to-back random stream at full throughput.
        base     = popCount;
        stalls   = 0;
        outReady = 1'b1;
        inValid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom(), $urandom(), logic'($urandom_range(0, 1)), randSub());
            if (!inReady) stalls++;
            tick();
        end
        inValid = 1'b0;
        extra   = 0;
        while (popCount < base + 100 && extra < 50) begin
            tick();
            extra++;
        end
        checkOutput("stream_stalls", 64'(stalls), 64'd0);
        checkOutput("stream_count", 64'(popCount - base), 64'd100);
        checkOutput("stream_drain", 64'(extra), 64'd4);

        // Output stalled while feeding: exactly NSTG accepts, held output stable.
        outReady = 1'b0;
        acc      = 0;
        seen     = 1'b0;
        unstable = 0;
        held     = '0;
        applyStimulus($urandom(), $urandom(), logic'($urandom_range(0, 1)), randSub());
        inValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            took = inReady;
            if (took) acc++;
            if (outValid) begin
                if (!seen) begin
                    held = sum;
                    seen = 1'b1;
                end else if (sum !== held) begin
                    unstable++;
                end
            end
            tick();
            if (took) applyStimulus($urandom(), $urandom(), logic'($urandom_range(0, 1)), randSub());
        end
        inValid = 1'b0;
        checkOutput("stall_accepts", 64'(acc), 64'd4);
        checkOutput("stall_in_ready", 64'(inReady), 64'd0);
        checkOutput("stall_out_valid", 64'(seen), 64'd1);
        checkOutput("stall_sum_stable", 64'(unstable), 64'd0);
        base     = popCount;
        outReady = 1'b1;
        for (int t = 0; t < 20 && popCount < base + 4; t++) tick();
        for (int t = 0; t < 5; t++) tick();
        checkOutput("stall_release_count", 64'(popCount - base), 64'd4);

        // Reset with three operations in flight.
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom() | 32'h1, $urandom(), 1'b1, 1'b0);
            tick();
        end
        inValid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_in_ready", 64'(inReady), 64'd1);
        base = popCount;
        runDirected("post_reset", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0,
                    32'h0000_0030, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) tick();
        checkOutput("post_reset_count", 64'(popCount - base), 64'd1);

        // Narrow configuration: 16 bits, four 4-bit stages.
        opA16     = 16'h1234;
        opB16     = 16'hEDCC;
        inValid16 = 1'b1;
        tick();
        inValid16 = 1'b0;
        cyc = 1;
        while (!outValid16 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("w16_latency", 64'(cyc), 64'd4);
        checkOutput("w16_sum", 64'(sum16), 64'h0000);
        checkOutput("w16_cout", 64'(cout16), 64'd1);
        checkOutput("w16_ovf", 64'(ovf16), 64'd0);
        tick();

        checkOutput("sb_leftover", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
